// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator-side controller for the 8-bit ALU.
// Accepts one decoded arithmetic/logic instruction, reads its two operands
// from the register file and drives the ALU for a single execute cycle. It
// then writes the result back one byte per cycle: R1:R0 for MUL, rd
// otherwise. SREG may load the ALU flags only in that execute cycle.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start, instr_op, rd_addr, rr_addr
//                                 decoder request (sampled only in IDLE)
//   busy, done, err               status; done/err are one-cycle pulses
//   rf_rd_addr_a/b, rf_rd_data_a/b
//                                 register-file read ports (data combinational)
//   rf_wr_en, rf_wr_addr, rf_wr_data
//                                 register-file write port
//   alu_arg1/2, alu_op, alu_use_carry, alu_q
//                                 ALU drive and 16-bit result
//   sreg_in, alu_mem_write, alu_mem_data
//                                 SREG feedback and SREG-load select/value
//
// Build option: define ALU_SEQ_COMPARE_EN to execute CP/CPC (ops 12/13)
// as flag-only SUB/SBC. Without it, ops 12-15 are all illegal.
//
// All control outputs are registered. Each one is computed from the state
// being entered, so it is valid for the whole cycle spent in that state.
// alu_mem_data is a straight copy of sreg_in, because SREG must hold its
// value whenever the ALU is not loading it.

module alu_sequencer #(
    parameter int unsigned RF_ADDR_W   = 5,
    parameter int unsigned MUL_LO_ADDR = 0,
    parameter int unsigned MUL_HI_ADDR = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           instr_op,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    input  logic [RF_ADDR_W-1:0] rr_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RF_ADDR_W-1:0] rf_rd_addr_a,
    output logic [RF_ADDR_W-1:0] rf_rd_addr_b,
    input  logic [7:0]           rf_rd_data_a,
    input  logic [7:0]           rf_rd_data_b,
    output logic                 rf_wr_en,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [7:0]           rf_wr_data,
    output logic [7:0]           alu_arg1,
    output logic [7:0]           alu_arg2,
    output logic [2:0]           alu_op,
    output logic                 alu_use_carry,
    input  logic [15:0]          alu_q,
    input  logic [7:0]           sreg_in,
    output logic                 alu_mem_write,
    output logic [7:0]           alu_mem_data
);

    // Instruction encodings from the decoder
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_EOR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_CP  = 4'd12;
    localparam logic [3:0] OP_CPC = 4'd13;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_MUL = 3'd2;
    localparam logic [2:0] ALU_SHL = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WB_LO = 3'd3,
        WB_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Map an instruction to the ALU op
    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADC:                 alu_op_of = ALU_ADD;
            OP_SUB, OP_SBC, OP_CP, OP_CPC:  alu_op_of = ALU_SUB;
            OP_MUL:                         alu_op_of = ALU_MUL;
            OP_LSL, OP_ROL:                 alu_op_of = ALU_SHL;
            OP_LSR, OP_ROR:                 alu_op_of = ALU_SHR;
            OP_AND:                         alu_op_of = ALU_AND;
            OP_OR:                          alu_op_of = ALU_OR;
            OP_EOR:                         alu_op_of = ALU_XOR;
            default:                        alu_op_of = ALU_ADD;
        endcase
    endfunction

    // Instructions that consume the incoming carry flag
    function automatic logic uses_carry(input logic [3:0] op);
        uses_carry = (op == OP_ADC) || (op == OP_SBC) || (op == OP_ROL) ||
                     (op == OP_ROR) || (op == OP_CPC);
    endfunction

    // Single-operand shifts and rotates present 0 as the second operand
    function automatic logic is_shift(input logic [3:0] op);
        is_shift = (op >= OP_LSL) && (op <= OP_ROR);
    endfunction

    // Compares update flags only; they never reach writeback
    function automatic logic is_cmp(input logic [3:0] op);
        is_cmp = (op == OP_CP) || (op == OP_CPC);
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_COMPARE_EN
        op_legal = (op <= OP_CPC);
`else
        op_legal = (op <= OP_MUL);
`endif
    endfunction

    state_t                 state, next_state;
    logic [3:0]             op_r, op_nx;
    logic [RF_ADDR_W-1:0]   rd_r, rd_nx;
    logic [RF_ADDR_W-1:0]   rr_r, rr_nx;
    logic                   illegal_r, illegal_nx;
    logic [15:0]            res, res_nx;

    logic                   busy_nx, done_nx, err_nx;
    logic [RF_ADDR_W-1:0]   rd_addr_a_nx, rd_addr_b_nx;
    logic                   wr_en_nx;
    logic [RF_ADDR_W-1:0]   wr_addr_nx;
    logic [7:0]             wr_data_nx;
    logic [7:0]             arg1_nx, arg2_nx;
    logic [2:0]             alu_op_nx;
    logic                   use_carry_nx;
    logic                   mem_write_nx;

    assign alu_mem_data = sreg_in;

    // Next state, then the outputs for the state being entered
    always_comb begin
        next_state   = state;
        op_nx        = op_r;
        rd_nx        = rd_r;
        rr_nx        = rr_r;
        illegal_nx   = illegal_r;
        res_nx       = res;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        rd_addr_a_nx = '0;
        rd_addr_b_nx = '0;
        wr_en_nx     = 1'b0;
        wr_addr_nx   = '0;
        wr_data_nx   = 8'h00;
        arg1_nx      = 8'h00;
        arg2_nx      = 8'h00;
        alu_op_nx    = ALU_ADD;
        use_carry_nx = 1'b0;
        mem_write_nx = 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    op_nx      = instr_op;
                    rd_nx      = rd_addr;
                    rr_nx      = rr_addr;
                    illegal_nx = !op_legal(instr_op);
                    next_state = illegal_nx ? DONE : READ;
                end
            end
            READ:    next_state = EXEC;
            EXEC: begin
                res_nx     = alu_q;
                next_state = is_cmp(op_r) ? DONE : WB_LO;
            end
            WB_LO:   next_state = (op_r == OP_MUL) ? WB_HI : DONE;
            WB_HI:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase

        busy_nx = (next_state != IDLE);

        case (next_state)
            READ: begin
                rd_addr_a_nx = rd_nx;
                rd_addr_b_nx = rr_nx;
            end
            EXEC: begin
                // Read data is valid now; the ALU argument registers hold
                // the operands for the execute cycle, so a later writeback
                // to rd cannot disturb them.
                arg1_nx      = rf_rd_data_a;
                arg2_nx      = is_shift(op_nx) ? 8'h00 : rf_rd_data_b;
                alu_op_nx    = alu_op_of(op_nx);
                use_carry_nx = uses_carry(op_nx);
                mem_write_nx = 1'b0;
            end
            WB_LO: begin
                wr_en_nx   = 1'b1;
                wr_addr_nx = (op_nx == OP_MUL) ? RF_ADDR_W'(MUL_LO_ADDR) : rd_nx;
                wr_data_nx = res_nx[7:0];
            end
            WB_HI: begin
                wr_en_nx   = 1'b1;
                wr_addr_nx = RF_ADDR_W'(MUL_HI_ADDR);
                wr_data_nx = res_nx[15:8];
            end
            DONE: begin
                done_nx = 1'b1;
                err_nx  = illegal_nx;
            end
            default: ;
        endcase
    end

    // State, instruction context and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            op_r          <= 4'd0;
            rd_r          <= '0;
            rr_r          <= '0;
            illegal_r     <= 1'b0;
            res           <= 16'h0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rf_rd_addr_a  <= '0;
            rf_rd_addr_b  <= '0;
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= '0;
            rf_wr_data    <= 8'h00;
            alu_arg1      <= 8'h00;
            alu_arg2      <= 8'h00;
            alu_op        <= ALU_ADD;
            alu_use_carry <= 1'b0;
            alu_mem_write <= 1'b1;
        end else begin
            state         <= next_state;
            op_r          <= op_nx;
            rd_r          <= rd_nx;
            rr_r          <= rr_nx;
            illegal_r     <= illegal_nx;
            res           <= res_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            err           <= err_nx;
            rf_rd_addr_a  <= rd_addr_a_nx;
            rf_rd_addr_b  <= rd_addr_b_nx;
            rf_wr_en      <= wr_en_nx;
            rf_wr_addr    <= wr_addr_nx;
            rf_wr_data    <= wr_data_nx;
            alu_arg1      <= arg1_nx;
            alu_arg2      <= arg2_nx;
            alu_op        <= alu_op_nx;
            alu_use_carry <= use_carry_nx;
            alu_mem_write <= mem_write_nx;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. It surrounds the DUT with a register file,
// an 8-bit ALU with ITHSVNZC flags and an SREG that follows alu_mem_write.
// Register-file writes are checked against a queue of expected writes.
`timescale 1ns/1ps

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  instr_op;
    logic [4:0]  rd_addr, rr_addr;
    logic        busy, done, err;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [7:0]  rf_rd_data_a, rf_rd_data_b;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  alu_arg1, alu_arg2;
    logic [2:0]  alu_op;
    logic        alu_use_carry;
    logic [15:0] alu_q;
    logic [7:0]  sreg_in;
    logic        alu_mem_write;
    logic [7:0]  alu_mem_data;

    always #5 clk = ~clk;

    alu_sequencer #(.RF_ADDR_W(5), .MUL_LO_ADDR(0), .MUL_HI_ADDR(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr_op(instr_op),
        .rd_addr(rd_addr), .rr_addr(rr_addr), .busy(busy), .done(done), .err(err),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_op(alu_op),
        .alu_use_carry(alu_use_carry), .alu_q(alu_q), .sreg_in(sreg_in),
        .alu_mem_write(alu_mem_write), .alu_mem_data(alu_mem_data)
    );

    // ---------------- environment: register file, ALU, SREG ----------------
    logic [7:0]  rf [32];
    logic [7:0]  sreg;
    logic        pl_en, pl_sreg_en;
    logic [4:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [23:0] alu_res;

    assign rf_rd_data_a = rf[rf_rd_addr_a];
    assign rf_rd_data_b = rf[rf_rd_addr_b];
    assign sreg_in      = sreg;

    // ALU reference: returns {flags, q}
    function automatic logic [23:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op, input logic uc,
                                              input logic [7:0] sr);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r, f;
        logic        ci;
        ci = uc & sr[0];
        f  = sr;
        r  = 8'h00;
        p  = 16'h0000;
        s  = 9'h000;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
                r = s[7:0];
                f[0] = s[8];
                f[5] = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, ci}) > 5'd15;
                f[3] = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b} - {8'h00, ci};
                r = s[7:0];
                f[0] = s[8];
                f[5] = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'h0, ci});
                f[3] = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: begin
                p = {8'h00, a} * {8'h00, b};
                f[0] = p[15];
                f[1] = (p == 16'h0000);
            end
            3'd3: begin r = {a[6:0], ci}; f[0] = a[7]; f[5] = a[3]; f[3] = r[7] ^ a[7]; end
            3'd4: begin r = {ci, a[7:1]}; f[0] = a[0]; f[3] = r[7] ^ a[0]; end
            3'd5: begin r = a & b; f[3] = 1'b0; end
            3'd6: begin r = a | b; f[3] = 1'b0; end
            default: begin r = a ^ b; f[3] = 1'b0; end
        endcase
        if (op != 3'd2) begin
            f[2] = r[7];
            f[1] = (r == 8'h00);
            f[4] = f[2] ^ f[3];
            p    = {8'h00, r};
        end
        return {f, p};
    endfunction

    assign alu_res = alu_model(alu_arg1, alu_arg2, alu_op, alu_use_carry, sreg);
    assign alu_q   = alu_res[15:0];

    always @(posedge clk) begin
        if (pl_en)         rf[pl_addr] <= pl_data;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        if (pl_sreg_en)    sreg <= pl_data;
        else               sreg <= alu_mem_write ? alu_mem_data : alu_res[23:16];
    end

    // Architectural result of an instruction, independent of the ALU encoding
    function automatic logic [7:0] isa_result(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic c);
        case (op)
            4'd0:    isa_result = a + b;
            4'd1:    isa_result = a + b + {7'h00, c};
            4'd2:    isa_result = a - b;
            4'd3:    isa_result = a - b - {7'h00, c};
            4'd4:    isa_result = a & b;
            4'd5:    isa_result = a | b;
            4'd6:    isa_result = a ^ b;
            4'd7:    isa_result = {a[6:0], 1'b0};
            4'd8:    isa_result = {a[6:0], c};
            4'd9:    isa_result = {1'b0, a[7:1]};
            4'd10:   isa_result = {c, a[7:1]};
            default: isa_result = 8'h00;
        endcase
    endfunction

    // ---------------- checking and scoreboard ----------------
    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  mw0_cnt  = 0;
    int  done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT drives
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (!alu_mem_write) mw0_cnt++;
        if (done) done_cnt++;
        if (rf_wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(rf_wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_wr_addr), 32'(e.addr));
                check("wr_data", 32'(rf_wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_sreg(input logic [7:0] d);
        @(posedge clk); #1;
        pl_sreg_en = 1'b1; pl_data = d;
        @(posedge clk); #1;
        pl_sreg_en = 1'b0;
    endtask

    // Issue one instruction and check latency, err, execute-cycle count and writes.
    // With hold set, start stays high with different inputs while busy.
    task automatic run_instr(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rr,
                             input int exp_cyc, input logic exp_err, input int exp_exec,
                             input bit hold);
        int   cyc;
        int   mw0_start;
        logic got_err;
        cyc = 0;
        got_err = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; instr_op = op; rd_addr = rd; rr_addr = rr;
        @(posedge clk); #1;
        mw0_start = mw0_cnt;
        if (hold) begin
            instr_op = 4'd11; rd_addr = 5'd9; rr_addr = 5'd9;
        end else begin
            start = 1'b0;
        end
        for (int k = 1; k <= 8 && cyc == 0; k++) begin
            tick();
            if (k == 1) check("busy_c1", 32'(busy), 32'd1);
            if (done) begin
                cyc = k;
                got_err = err;
            end
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("err", 32'(got_err), 32'(exp_err));
        check("exec_cycles", 32'(mw0_cnt - mw0_start), 32'(exp_exec));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, b, c_in;
        int         mw0_s, done_s;
        logic [7:0] sreg_s;

        reset_n = 1'b0; start = 1'b0; instr_op = 4'd0; rd_addr = 5'd0; rr_addr = 5'd0;
        pl_en = 1'b0; pl_sreg_en = 1'b0; pl_addr = 5'd0; pl_data = 8'h00;

        // Reset state
        set_sreg(8'h00);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_mem_write", 32'(alu_mem_write), 32'd1);
        check("rst_mem_data", 32'(alu_mem_data), 32'h00);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rd_addr_a", 32'(rf_rd_addr_a), 32'd0);
        reset_n = 1'b1;

        // ADD R2,R3: 0x3C + 0x45
        set_reg(5'd2, 8'h3C);
        set_reg(5'd3, 8'h45);
        exp_q.push_back('{addr: 5'd2, data: 8'h81});
        run_instr(4'd0, 5'd2, 5'd3, 4, 1'b0, 1, 1'b0);
        check("add_sreg", 32'(sreg), 32'h2C);

        // Flag hold over idle cycles
        mw0_s = mw0_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("idle_mem_write", 32'(mw0_cnt - mw0_s), 32'd0);
        check("idle_sreg", 32'(sreg), 32'h2C);

        // MUL R4,R5: 0xFF * 0xFF = 0xFE01 into R1:R0
        set_reg(5'd4, 8'hFF);
        set_reg(5'd5, 8'hFF);
        exp_q.push_back('{addr: 5'd0, data: 8'h01});
        exp_q.push_back('{addr: 5'd1, data: 8'hFE});
        run_instr(4'd11, 5'd4, 5'd5, 5, 1'b0, 1, 1'b0);
        check("mul_sreg", 32'(sreg), 32'h2D);

        // Illegal ops
        for (int op = 14; op <= 15; op++) begin
            run_instr(4'(op), 5'd2, 5'd3, 1, 1'b1, 0, 1'b0);
            check("illegal_sreg", 32'(sreg), 32'h2D);
        end

        // Compare R6,R7 with equal operands
        set_reg(5'd6, 8'h10);
        set_reg(5'd7, 8'h10);
`ifdef ALU_SEQ_COMPARE_EN
        run_instr(4'd12, 5'd6, 5'd7, 3, 1'b0, 1, 1'b0);
        check("cp_sreg", 32'(sreg), 32'h02);
`else
        run_instr(4'd12, 5'd6, 5'd7, 1, 1'b1, 0, 1'b0);
        check("cp_sreg", 32'(sreg), 32'h2D);
        run_instr(4'd13, 5'd6, 5'd7, 1, 1'b1, 0, 1'b0);
        check("cpc_sreg", 32'(sreg), 32'h2D);
`endif

        // Reset during EXEC aborts the instruction
        set_reg(5'd2, 8'h3C);
        sreg_s = sreg;
        @(posedge clk); #1;
        start = 1'b1; instr_op = 4'd0; rd_addr = 5'd2; rr_addr = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        tick();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mem_write", 32'(alu_mem_write), 32'd1);
        done_s = done_cnt;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_done", 32'(done_cnt - done_s), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_sreg", 32'(sreg), 32'(sreg_s));

        // Each legal non-MUL op with random operands
        for (int op = 0; op <= 10; op++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            set_reg(5'(8 + op), a);
            set_reg(5'(20 + op), b);
            c_in = sreg;
            exp_q.push_back('{addr: 5'(8 + op), data: isa_result(4'(op), a, b, c_in[0])});
            run_instr(4'(op), 5'(8 + op), 5'(20 + op), 4, 1'b0, 1, 1'b0);
        end

        // rd == rr: operand is read before writeback
        set_reg(5'd30, 8'h5B);
        exp_q.push_back('{addr: 5'd30, data: 8'hB6});
        run_instr(4'd0, 5'd30, 5'd30, 4, 1'b0, 1, 1'b0);

        // start held high with new inputs while busy is ignored
        set_reg(5'd10, 8'hA5);
        set_reg(5'd11, 8'h0F);
        exp_q.push_back('{addr: 5'd10, data: 8'hAA});
        run_instr(4'd6, 5'd10, 5'd11, 4, 1'b0, 1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("hold_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
